// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter for the async FIFO bank; FIFO_RD_ARB_POP_CNT_EN adds per-channel pop counters.
// Latency: empty low -> m_valid two cycles later. When m_ready is low, it stops popping once the 2-entry buffer is committed.
module fifo_rd_arbiter #(
  parameter int DATA_WIDTH = 41,
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst_n,
  output logic [NUM_CH-1:0]            rd_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_CH-1:0]            empty,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_ch,
  output logic [NUM_CH*CNT_W-1:0]      pop_cnt
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [CH_W-1:0]       inflight_ch;
  logic [CH_W-1:0]       rr_ptr;
  logic [DATA_WIDTH-1:0] head_dat, tail_dat;
  logic [CH_W-1:0]       head_ch, tail_ch;

  logic                  pop, cap, found, credit_ok, issue;
  logic [CH_W-1:0]       winner;
  logic [CH_W:0]         idx;
  logic [DATA_WIDTH-1:0] cap_dat;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_dat;
  assign m_ch    = head_ch;
  assign pop     = m_valid & m_ready;
  assign cap     = inflight;

  // Words already committed (buffered or returning) must fit after this cycle's pop.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // Scan from the highest offset down, so the nearest non-empty channel to rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (!empty[idx[CH_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[CH_W-1:0];
      end
    end
  end

  // Gated by reset so no pop reaches the FIFOs while the arbiter is held.
  assign issue = found & credit_ok & rd_rst_n;
  assign rd_en = issue ? (NUM_CH'(1) << winner) : '0;

  always_comb begin
    cap_dat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (inflight_ch == CH_W'(c)) cap_dat = rd_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      occ         <= 2'd0;
      inflight    <= 1'b0;
      inflight_ch <= '0;
      rr_ptr      <= '0;
      head_dat    <= '0;
      head_ch     <= '0;
      tail_dat    <= '0;
      tail_ch     <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_ch <= winner;
        rr_ptr      <= (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
      end
      case ({cap, pop})
        2'b01: begin
          head_dat <= tail_dat;
          head_ch  <= tail_ch;
          occ      <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            head_dat <= cap_dat;
            head_ch  <= inflight_ch;
          end else begin
            tail_dat <= cap_dat;
            tail_ch  <= inflight_ch;
          end
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_dat <= cap_dat;
            head_ch  <= inflight_ch;
          end else begin
            head_dat <= tail_dat;
            head_ch  <= tail_ch;
            tail_dat <= cap_dat;
            tail_ch  <= inflight_ch;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_ARB_POP_CNT_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
        cnt <= '0;
      end else if (rd_en[c] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign pop_cnt[c*CNT_W +: CNT_W] = cnt;
  end
`else
  assign pop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: two modelled FIFOs, directed vectors, monitor pops expected words.
module tb_fifo_rd_arbiter;
  localparam int DW   = 41;
  localparam int NC   = 2;
  localparam int CNTW = 4;

  logic          rd_clk   = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic [NC-1:0] rd_en;
  logic [NC-1:0] empty;
  logic [DW-1:0] rd_d0 = '0;
  logic [DW-1:0] rd_d1 = '0;
  logic          m_valid;
  logic          m_ready  = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_ch;
  logic [NC*CNTW-1:0] pop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   sb[$];
  int push0 = 0, push1 = 0, popped0 = 0, popped1 = 0;
  logic [DW-1:0] tmp0, tmp1;
  logic [DW:0]   exp_w;

  fifo_rd_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NC), .CNT_W(CNTW)) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .rd_en    (rd_en),
    .rd_data  ({rd_d1, rd_d0}),
    .empty    (empty),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_ch     (m_ch),
    .pop_cnt  (pop_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  assign empty = {push1 == popped1, push0 == popped0};

  // FIFO read ports: data appears the cycle after rd_en.
  always @(posedge rd_clk) begin
    if (rd_en[0] && q0.size() > 0) begin
      tmp0 = q0.pop_front();
      rd_d0   <= tmp0;
      popped0 <= popped0 + 1;
    end
    if (rd_en[1] && q1.size() > 0) begin
      tmp1 = q1.pop_front();
      rd_d1   <= tmp1;
      popped1 <= popped1 + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
  endtask

  always @(negedge rd_clk) begin
    chk("rd_en_legal", 64'(((rd_en & empty) == '0) && $onehot0(rd_en)), 64'(1));
    if (rd_rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected actual=%0h_%0h required=none at %0t", m_ch, m_data, $time);
      end else begin
        exp_w = sb.pop_front();
        chk("sb_word", 64'({m_ch, m_data}), 64'(exp_w));
      end
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic put(input logic ch, input logic [DW-1:0] w);
    if (ch) begin q1.push_back(w); push1++; end
    else begin q0.push_back(w); push0++; end
  endtask

  task automatic expect_w(input logic ch, input logic [DW-1:0] w);
    sb.push_back({ch, w});
  endtask

  task automatic rst_release();
    q0.delete();
    q1.delete();
    push0 = popped0;
    push1 = popped1;
    sb.delete();
    tick();
    tick();
    rd_rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    #1;
    rst_release();
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    chk(nm, 64'(sb.size()), 64'(0));
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] vec;
    int npulse;

    tick();
    tick();
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data",  64'(m_data),  64'(0));
    chk("rst_m_ch",    64'(m_ch),    64'(0));
    chk("rst_rd_en",   64'(rd_en),   64'(0));
    chk("rst_pop_cnt", 64'(pop_cnt), 64'(0));
    rd_rst_n = 1'b1;
    m_ready  = 1'b1;
    tick();

    // Single word: rd_en in cycle 0, m_valid in cycle 2.
    put(1'b0, 41'h1_2345_6789A);
    expect_w(1'b0, 41'h1_2345_6789A);
    #1;
    chk("t1_rd_en_c0", 64'(rd_en), 64'(2'b01));
    tick();
    chk("t1_valid_c1", 64'(m_valid), 64'(0));
    tick();
    chk("t1_valid_c2", 64'(m_valid), 64'(1));
    chk("t1_data_c2",  64'(m_data),  64'(41'h1_2345_6789A));
    chk("t1_ch_c2",    64'(m_ch),    64'(0));
    tick();
`ifdef FIFO_RD_ARB_POP_CNT_EN
    chk("t1_pop_cnt", 64'(pop_cnt), 64'(8'h01));
`else
    chk("t1_pop_cnt", 64'(pop_cnt), 64'(8'h00));
`endif
    drain("t1_drain");

    // Round robin with both channels loaded: 0,1,0,1... one word per cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(1'b0, DW'(41'h100 + i));
      put(1'b1, DW'(41'h200 + i));
      expect_w(1'b0, DW'(41'h100 + i));
      expect_w(1'b1, DW'(41'h200 + i));
    end
    #1;
    vec = '0;
    for (int k = 0; k < 12; k++) begin
      vec[k] = m_valid;
      tick();
    end
    chk("t2_valid_run", 64'(vec), 64'(12'h3FC));
    drain("t2_drain");

    // Backpressure: only two pops are committed while m_ready is low.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, DW'(41'h300 + i));
      expect_w(1'b1, DW'(41'h300 + i));
    end
    #1;
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_en != '0) npulse++;
      tick();
    end
    chk("t3_pulses",  64'(npulse),  64'(2));
    chk("t3_occ",     64'(dut.occ), 64'(2));
    chk("t3_valid",   64'(m_valid), 64'(1));
    chk("t3_head",    64'(m_data),  64'(41'h300));
    m_ready = 1'b1;
    drain("t3_drain");

    // Empty skip: ch0 empty, rr_ptr at 0, ch1 served every cycle.
    for (int i = 0; i < 3; i++) begin
      put(1'b1, DW'(41'h400 + i));
      expect_w(1'b1, DW'(41'h400 + i));
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_rd_en", 64'(rd_en), 64'(2'b10));
      tick();
    end
    chk("t4_rd_en_idle", 64'(rd_en), 64'(0));
    drain("t4_drain");

    // Reset mid-stream while a pop is in flight, then resume from ch0.
    for (int i = 0; i < 4; i++) begin
      put(1'b0, DW'(41'h500 + i));
      put(1'b1, DW'(41'h600 + i));
      expect_w(1'b0, DW'(41'h500 + i));
      expect_w(1'b1, DW'(41'h600 + i));
    end
    tick();
    tick();
    tick();
    #2;
    rd_rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",   64'(m_valid), 64'(0));
    chk("t5_rst_rd_en",   64'(rd_en),   64'(0));
    chk("t5_rst_pop_cnt", 64'(pop_cnt), 64'(0));
    rst_release();
    put(1'b1, 41'h700);
    put(1'b0, 41'h800);
    put(1'b1, 41'h701);
    put(1'b0, 41'h801);
    expect_w(1'b0, 41'h800);
    expect_w(1'b1, 41'h700);
    expect_w(1'b0, 41'h801);
    expect_w(1'b1, 41'h701);
    #1;
    chk("t5_resume_rd_en", 64'(rd_en), 64'(2'b01));
    drain("t5_drain");

    // Pop counter saturation on ch0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      put(1'b0, DW'(41'h900 + i));
      expect_w(1'b0, DW'(41'h900 + i));
    end
    drain("t6_drain");
`ifdef FIFO_RD_ARB_POP_CNT_EN
    chk("t6_pop_cnt", 64'(pop_cnt), 64'(8'h0F));
`else
    chk("t6_pop_cnt", 64'(pop_cnt), 64'(8'h00));
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
